// File: rtl/fa.sv
// Full adder with a combinational sum/carry path, plus a registered stage that
// runs either as a parallel pipeline register or as a bit-serial adder.
module fa #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ci,
    input  logic             x,
    input  logic             y,
    input  logic             en,
    input  logic             ser,
    input  logic             clr,
    output logic             co,
    output logic             s,
    output logic             s_q,
    output logic             co_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] nbits
);

    localparam logic [CNT_W-1:0] NBITS_MAX = '1;

    logic c_ser;
    logic s_ser;
    logic co_ser;

    // The combinational outputs depend only on ci, x and y, so they stay valid
    // without a clock and whatever the control inputs are doing.
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

    // A clear opens a new serial word, so that same edge adds with a carry-in of 0.
    assign c_ser  = clr ? 1'b0 : carry_q;
    assign s_ser  = x ^ y ^ c_ser;
    assign co_ser = (x & y) | (x & c_ser) | (y & c_ser);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            co_q    <= 1'b0;
            carry_q <= 1'b0;
            nbits   <= '0;
        end else begin
            if (en) begin
                if (ser) begin
                    s_q     <= s_ser;
                    co_q    <= co_ser;
                    carry_q <= co_ser;
                end else begin
                    s_q  <= s;
                    co_q <= co;
                    if (clr) begin
                        carry_q <= 1'b0;
                    end
                end
            end else if (clr) begin
                carry_q <= 1'b0;
            end

            if (clr) begin
                nbits <= en ? CNT_W'(1) : '0;
            end else if (en && (nbits != NBITS_MAX)) begin
                nbits <= nbits + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fa.sv
// Directed self-checking bench for fa: truth table, parallel and serial
// registered behaviour, asynchronous reset, hold, and counter saturation.
module tb_fa;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic       ci, x, y, en, ser, clr;
    logic       co, s, s_q, co_q, carry_q;
    logic [7:0] nbits;
    logic       co2, s2, s_q2, co_q2, carry_q2;
    logic [1:0] nbits2;

    int checks = 0;
    int errors = 0;

    fa #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ci(ci), .x(x), .y(y), .en(en), .ser(ser), .clr(clr),
        .co(co), .s(s), .s_q(s_q), .co_q(co_q), .carry_q(carry_q), .nbits(nbits)
    );

    fa #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ci(ci), .x(x), .y(y), .en(en), .ser(ser), .clr(clr),
        .co(co2), .s(s2), .s_q(s_q2), .co_q(co_q2), .carry_q(carry_q2), .nbits(nbits2)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s_tab;
        logic [7:0] co_tab;
        logic [1:0] sat_exp [5];
        logic [2:0] v;

        s_tab  = 8'b1001_0110;
        co_tab = 8'b1110_1000;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Combinational truth table, clock stopped, controls and reset left unknown.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {ci, x, y} = v;
            #1;
            check($sformatf("tt_s_%0d", i), 32'(s), 32'(s_tab[i]));
            check($sformatf("tt_co_%0d", i), 32'(co), 32'(co_tab[i]));
        end

        // Reset state.
        rst = 1'b1; en = 1'b0; ser = 1'b0; clr = 1'b0; ci = 1'b0; x = 1'b0; y = 1'b0;
        #1;
        check("rst_s_q", 32'(s_q), 0);
        check("rst_co_q", 32'(co_q), 0);
        check("rst_carry_q", 32'(carry_q), 0);
        check("rst_nbits", 32'(nbits), 0);
        clk_run = 1'b1;
        step();
        rst = 1'b0;

        // Parallel registered step: ci=1, x=1, y=0 -> s=0, co=1.
        ser = 1'b0; en = 1'b1; ci = 1'b1; x = 1'b1; y = 1'b0;
        step();
        en = 1'b0;
        check("par_s_q", 32'(s_q), 0);
        check("par_co_q", 32'(co_q), 1);
        check("par_nbits", 32'(nbits), 1);
        check("par_carry_q", 32'(carry_q), 0);

        // Serial 3 + 1 LSB first, ci held at 1 to show it is ignored.
        ser = 1'b1; en = 1'b1; ci = 1'b1; clr = 1'b1; x = 1'b1; y = 1'b1;
        step();
        check("ser_b0_s_q", 32'(s_q), 0);
        check("ser_b0_carry", 32'(carry_q), 1);
        clr = 1'b0; x = 1'b1; y = 1'b0;
        step();
        check("ser_b1_s_q", 32'(s_q), 0);
        check("ser_b1_carry", 32'(carry_q), 1);
        x = 1'b0; y = 1'b0;
        step();
        check("ser_b2_s_q", 32'(s_q), 1);
        check("ser_b2_carry", 32'(carry_q), 0);
        step();
        en = 1'b0;
        check("ser_b3_s_q", 32'(s_q), 0);
        check("ser_final_carry", 32'(carry_q), 0);
        check("ser_nbits", 32'(nbits), 4);

        // Serial step leaving carry_q=1, then reset between edges.
        ser = 1'b1; en = 1'b1; clr = 1'b1; ci = 1'b0; x = 1'b1; y = 1'b1;
        step();
        en = 1'b0; clr = 1'b0;
        check("pre_rst_carry", 32'(carry_q), 1);
        check("pre_rst_co_q", 32'(co_q), 1);
        #2;
        rst = 1'b1; ci = 1'b0; x = 1'b1; y = 1'b0;
        #1;
        check("arst_s_q", 32'(s_q), 0);
        check("arst_co_q", 32'(co_q), 0);
        check("arst_carry_q", 32'(carry_q), 0);
        check("arst_nbits", 32'(nbits), 0);
        check("arst_s", 32'(s), 1);
        check("arst_co", 32'(co), 0);
        ci = 1'b1; y = 1'b1;
        #1;
        check("arst_s_b", 32'(s), 1);
        check("arst_co_b", 32'(co), 1);
        @(negedge clk);
        rst = 1'b0;

        // First enabled edge after reset sees carry_q=0: 1+0+0 -> s=1, co=0.
        ser = 1'b1; en = 1'b1; clr = 1'b0; ci = 1'b1; x = 1'b1; y = 1'b0;
        step();
        en = 1'b0;
        check("post_rst_s_q", 32'(s_q), 1);
        check("post_rst_co_q", 32'(co_q), 0);
        check("post_rst_nbits", 32'(nbits), 1);

        // Hold with toggling data and mode.
        for (int i = 0; i < 3; i++) begin
            {ci, x, y} = (i == 1) ? 3'b000 : 3'b111;
            ser = (i == 1);
            step();
        end
        check("hold_s_q", 32'(s_q), 1);
        check("hold_co_q", 32'(co_q), 0);
        check("hold_nbits", 32'(nbits), 1);

        // Saturation on the 2-bit counter, then clear with enable.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        ser = 1'b0; en = 1'b1; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat_nbits2_%0d", i), 32'(nbits2), 32'(sat_exp[i]));
        end
        check("sat_nbits_wide", 32'(nbits), 5);
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b0;
        check("clr_en_nbits2", 32'(nbits2), 1);
        check("clr_en_nbits", 32'(nbits), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa.md
FA -- requirements
Module: fa

Interface
- REQ-001 The module SHALL have one parameter: CNT_W, default 8, width of the processed-bit counter.
- REQ-002 The module SHALL have port clk, input, 1 bit, the rising-edge clock for all registers.
- REQ-003 The module SHALL have port rst, input, 1 bit, asynchronous active-high reset.
- REQ-004 The module SHALL have ports ci, x and y, inputs, 1 bit each: carry-in and the two addend bits.
- REQ-005 The module SHALL have port en, input, 1 bit, register-stage enable.
- REQ-006 The module SHALL have port ser, input, 1 bit, mode select (0 = parallel, 1 = bit-serial).
- REQ-007 The module SHALL have port clr, input, 1 bit, synchronous clear of the serial carry (start of new word).
- REQ-008 The module SHALL have port co, output, 1 bit, combinational carry-out.
- REQ-009 The module SHALL have port s, output, 1 bit, combinational sum.
- REQ-010 The module SHALL have port s_q, output, 1 bit, registered sum.
- REQ-011 The module SHALL have port co_q, output, 1 bit, registered carry-out.
- REQ-012 The module SHALL have port carry_q, output, 1 bit, stored serial carry state.
- REQ-013 The module SHALL have port nbits, output, CNT_W bits, count of enabled bit operations.

Function
- REQ-014 s SHALL equal x XOR y XOR ci, and co SHALL equal majority(x, y, ci), i.e. (x&y)|(x&ci)|(y&ci).
- REQ-015 s and co SHALL be purely combinational, depend only on ci, x and y, and be valid with no clock toggling and with en, ser, clr, clk or rst unknown or floating.
- REQ-016 s and co SHALL settle within one simulation delta of an input change, with no internal delays.
- REQ-017 In parallel mode (ser=0, en=1), on each rising clk edge: s_q <= s, co_q <= co, carry_q unchanged.
- REQ-018 In serial mode (ser=1, en=1), on each rising clk edge, with effective carry-in c = (clr ? 0 : carry_q): s_q <= x^y^c, co_q <= maj(x,y,c), carry_q <= maj(x,y,c); ci is ignored.
- REQ-019 With clr=1 and en=1 in serial mode, the same edge SHALL use 0 as carry-in and store the new carry (clr and step occur simultaneously).
- REQ-020 With clr=1 and en=0, carry_q SHALL be cleared to 0; s_q and co_q SHALL hold.
- REQ-021 With en=0, s_q, co_q and nbits SHALL hold.
- REQ-022 nbits SHALL increment by 1 on each edge with en=1 and saturate at 2^CNT_W-1 (no wrap).
- REQ-023 clr SHALL also reset nbits to 0 on the same edge; if en=1 at the same time, nbits SHALL become 1.
- REQ-024 A mode change (ser toggled) SHALL take effect on the next edge without disturbing the stored registers.

Reset
- REQ-025 While rst=1, s_q, co_q, carry_q and nbits SHALL be 0, asynchronously and independent of clk.
- REQ-026 rst SHALL NOT affect s or co.
- REQ-027 Reset asserted mid-serial-word SHALL discard the carry; the first enabled edge after deassertion SHALL use carry_q=0.

Verification
- REQ-028 Combinational truth table, no clock: (ci,x,y)=000 -> co=0,s=0; 001 -> co=0,s=1; 010 -> co=0,s=1; 011 -> co=1,s0; also cover 100 -> 0/1, 101 -> 1/0, 110 -> 1/0, 111 -> 1/1.
- REQ-029 Parallel registered: rst pulse, ser=0, en=1, ci=1, x=1, y=0, one edge -> s_q=0, co_q=1, nbits=1, carry_q=0.
- REQ-030 Serial add 3+1 over 4 bits LSB first: clr=1 on first edge; (x,y) = (1,1),(1,0),(0,0),(0,0) -> s_q sequence 0,0,1,0 (sum 4), final carry_q=0.
- REQ-031 Async reset: carry_q=1 after a serial step, assert rst between edges -> carry_q, s_q, co_q, nbits go to 0 immediately; s and co still track their inputs.
- REQ-032 Saturation with CNT_W=2: hold en=1 for 5 edges -> nbits = 1,2,3,3,3; then clr=1 with en=1 -> nbits=1.
- REQ-033 Hold: en=0 with toggling inputs for 3 edges -> s_q, co_q and nbits unchanged.
